// File: rtl/counter_irq_ctrl_pkg.sv
// Shared constants for the counter interrupt controller: register addresses,
// edge-mode encodings and STATUS field offsets.
package counter_irq_pkg;

   localparam logic [1:0] ADDR_STATUS  = 2'd0;
   localparam logic [1:0] ADDR_MASK    = 2'd1;
   localparam logic [1:0] ADDR_EVCNT   = 2'd2;
   localparam logic [1:0] ADDR_EDGECFG = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_e;

   localparam int unsigned STATUS_PEND_LSB = 0;
   localparam int unsigned STATUS_OVF_LSB  = 3;

endpackage

// File: rtl/counter_irq_ctrl_sync_edge.sv
// One channel: multi-flop synchroniser into clk, a previous-value flop and
// single-cycle rise/fall strobes.
module counter_irq_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync;
      end
   end

   assign rise = sync & ~prev_q;
   assign fall = ~sync & prev_q;

endmodule

// File: rtl/counter_irq_ctrl.sv
// Counter terminal-count event/interrupt stage with a 4-word register window.
// Optional per-channel edge selection is enabled by COUNTER_IRQ_EDGESEL_EN.
module counter_irq_ctrl
   import counter_irq_pkg::*;
#(
   parameter int unsigned N_CH        = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EVCNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   counter_out_in,
   input  logic              bus_we,
   input  logic [1:0]        bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              irq
);

   logic [N_CH-1:0]    rise, fall, ev;
   logic [N_CH-1:0]    pending_q, overflow_q, mask_q;
   logic [N_CH-1:0]    pend_d, ovf_d, clr_pend, clr_ovf;
   logic [EVCNT_W-1:0] evcnt_q [N_CH];
   logic [EVCNT_W-1:0] evcnt_d [N_CH];
   logic               wr_status, wr_mask, wr_evcnt;
   logic               wdata_unused;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      counter_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk      (clk),
         .rst      (rst),
         .async_in (counter_out_in[g]),
         .rise     (rise[g]),
         .fall     (fall[g])
      );
   end

   assign wr_status    = bus_we && (bus_addr == ADDR_STATUS);
   assign wr_mask      = bus_we && (bus_addr == ADDR_MASK);
   assign wr_evcnt     = bus_we && (bus_addr == ADDR_EVCNT);
   assign wdata_unused = ^bus_wdata[31:STATUS_OVF_LSB+N_CH];

`ifdef COUNTER_IRQ_EDGESEL_EN
   logic [2*N_CH-1:0] edgecfg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         edgecfg_q <= '0;
      end else if (bus_we && (bus_addr == ADDR_EDGECFG)) begin
         edgecfg_q <= bus_wdata[2*N_CH-1:0];
      end
   end

   always_comb begin
      ev = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         case (edge_mode_e'(edgecfg_q[2*i +: 2]))
            EDGE_RISE: ev[i] = rise[i];
            EDGE_FALL: ev[i] = fall[i];
            EDGE_BOTH: ev[i] = rise[i] | fall[i];
            default:   ev[i] = 1'b0;
         endcase
      end
   end
`else
   logic [N_CH-1:0] fall_unused;

   assign fall_unused = fall;
   assign ev          = rise;
`endif

   // Set beats clear; overflow looks at pending as it was before any clear.
   always_comb begin
      clr_pend = wr_status ? bus_wdata[STATUS_PEND_LSB +: N_CH] : '0;
      clr_ovf  = wr_status ? bus_wdata[STATUS_OVF_LSB +: N_CH]  : '0;
      pend_d   = (pending_q & ~clr_pend) | ev;
      ovf_d    = (overflow_q & ~clr_ovf) | (ev & pending_q);
      for (int unsigned i = 0; i < N_CH; i++) begin
         evcnt_d[i] = evcnt_q[i];
         if (wr_evcnt) begin
            evcnt_d[i] = '0;
         end
         if (ev[i]) begin
            if (wr_evcnt) begin
               evcnt_d[i] = EVCNT_W'(1);
            end else if (!(&evcnt_q[i])) begin
               evcnt_d[i] = evcnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q  <= '0;
         overflow_q <= '0;
         mask_q     <= '0;
         irq        <= 1'b0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            evcnt_q[i] <= '0;
         end
      end else begin
         pending_q  <= pend_d;
         overflow_q <= ovf_d;
         irq        <= |(pending_q & mask_q);
         if (wr_mask) begin
            mask_q <= bus_wdata[N_CH-1:0];
         end
         for (int unsigned i = 0; i < N_CH; i++) begin
            evcnt_q[i] <= evcnt_d[i];
         end
      end
   end

   always_comb begin
      bus_rdata = '0;
      case (bus_addr)
         ADDR_STATUS: begin
            bus_rdata[STATUS_PEND_LSB +: N_CH] = pending_q;
            bus_rdata[STATUS_OVF_LSB +: N_CH]  = overflow_q;
         end
         ADDR_MASK: bus_rdata[N_CH-1:0] = mask_q;
         ADDR_EVCNT: begin
            for (int unsigned i = 0; i < N_CH; i++) begin
               bus_rdata[8*i +: EVCNT_W] = evcnt_q[i];
            end
         end
`ifdef COUNTER_IRQ_EDGESEL_EN
         ADDR_EDGECFG: bus_rdata[2*N_CH-1:0] = edgecfg_q;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_counter_irq_ctrl.sv
// Scoreboard bench for counter_irq_ctrl: event-level reference model with a
// fixed input-to-pending latency, directed scenarios plus random traffic.
module tb_counter_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  counter_out_in;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;

  always #5 clk = ~clk;

  counter_irq_ctrl #(.N_CH(3), .SYNC_STAGES(2), .EVCNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .counter_out_in (counter_out_in),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .irq            (irq)
  );

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    int unsigned at;
    int unsigned ch;
    bit          rising;
  } ev_t;

  chk_t        chkq[$];
  ev_t         evq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  bit          done    = 1'b0;

  logic [2:0]  m_pend, m_ovf, m_mask;
  logic [5:0]  m_cfg;
  int          m_cnt[3];
  logic        m_irq;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_ovf, m_pend};
      2'd1:    return {29'd0, m_mask};
      2'd2:    return {8'd0, 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
`ifdef COUNTER_IRQ_EDGESEL_EN
      default: return {26'd0, m_cfg};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic bit accepts(input int unsigned ch, input bit rising);
`ifdef COUNTER_IRQ_EDGESEL_EN
    logic [1:0] md;
    md = m_cfg[2*ch +: 2];
    case (md)
      2'b00:   return rising;
      2'b01:   return !rising;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
`else
    return rising && (ch < 3);
`endif
  endfunction

  // An input change made after edge n is sampled at n+1 and lands at n+3.
  task automatic set_in(input logic [2:0] v);
    for (int unsigned ch = 0; ch < 3; ch++) begin
      if (v[ch] !== counter_out_in[ch]) evq.push_back('{cyc + 3, ch, v[ch]});
    end
    counter_out_in = v;
  endtask

  task automatic step(input bit use_a, input logic [1:0] a,
                      input bit has_c, input string nm, input logic [31:0] exp);
    bit          r, we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ev, clrp, clro;
    r  = rst;
    we = bus_we;
    wa = bus_addr;
    wd = bus_wdata;
    ev = '0;
    while (evq.size() > 0 && evq[0].at <= cyc + 1) begin
      ev_t e;
      e = evq.pop_front();
      if (accepts(e.ch, e.rising)) ev[e.ch] = 1'b1;
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      m_pend = '0; m_ovf = '0; m_mask = '0; m_cfg = '0; m_irq = 1'b0;
      for (int unsigned i = 0; i < 3; i++) m_cnt[i] = 0;
      evq.delete();
    end else begin
      m_irq = |(m_pend & m_mask);
      clrp  = (we && wa == 2'd0) ? wd[2:0] : 3'd0;
      clro  = (we && wa == 2'd0) ? wd[5:3] : 3'd0;
      m_ovf  = (m_ovf & ~clro) | (ev & m_pend);
      m_pend = (m_pend & ~clrp) | ev;
      if (we && wa == 2'd1) m_mask = wd[2:0];
      for (int unsigned i = 0; i < 3; i++) begin
        if (we && wa == 2'd2) m_cnt[i] = 0;
        if (ev[i]) m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
      end
`ifdef COUNTER_IRQ_EDGESEL_EN
      if (we && wa == 2'd3) m_cfg = wd[5:0];
`endif
    end
    #1;
    bus_we   = 1'b0;
    bus_addr = use_a ? a : 2'($urandom_range(0, 3));
    chkq.push_back('{$sformatf("rdata@%0d", bus_addr), 1'b0, m_read(bus_addr)});
    chkq.push_back('{"irq", 1'b1, {31'd0, m_irq}});
    if (has_c) chkq.push_back('{nm, 1'b0, exp});
    #5;
  endtask

  task automatic tick();
    step(1'b0, 2'd0, 1'b0, "", 32'd0);
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    tick();
  endtask

  task automatic expect_reg(input string nm, input logic [1:0] a, input logic [31:0] exp);
    step(1'b1, a, 1'b1, nm, exp);
  endtask

  initial begin : monitor
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (chkq.size() > 0) begin
        c   = chkq.pop_front();
        act = c.is_irq ? {31'd0, irq} : bus_rdata;
        n_tests++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", c.name, act, c.exp, cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin : driver
    logic [1:0] a;
    rst = 1'b1; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; counter_out_in = '0;
    ticks(2);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_irq: got %b expected 0 (cycle %0d)", irq, cyc);
    end
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) expect_reg($sformatf("rst_reg%0d", i), 2'(i), 32'd0);

    wr(2'd1, 32'h1);
    set_in(3'b001);
    ticks(6);
    expect_reg("lat_status", 2'd0, 32'h1);
    wr(2'd0, 32'h1);
    ticks(2);
    set_in(3'b000);
    ticks(4);

    wr(2'd0, 32'h3f);
    wr(2'd2, 32'h0);
    for (int unsigned p = 0; p < 300; p++) begin
      set_in(3'b010); ticks(4);
      set_in(3'b000); ticks(4);
    end
    ticks(3);
    expect_reg("sat_evcnt", 2'd2, 32'h0000ff00);
    expect_reg("sat_status", 2'd0, 32'h12);
    wr(2'd0, 32'h12);
    expect_reg("sat_clear", 2'd0, 32'h0);

    set_in(3'b100); tick(); tick();
    wr(2'd0, 32'h4);
    ticks(2);
    expect_reg("race_first", 2'd0, 32'h4);
    set_in(3'b000); ticks(4);
    set_in(3'b100); tick(); tick();
    wr(2'd0, 32'h4);
    ticks(2);
    expect_reg("race_ovf", 2'd0, 32'h24);
    set_in(3'b000); ticks(4);
    wr(2'd0, 32'h3f);

    set_in(3'b111); ticks(4);
    set_in(3'b000); ticks(4);
    wr(2'd1, 32'h0);
    ticks(2);
    wr(2'd1, 32'h4);
    ticks(2);
    expect_reg("mask_rd", 2'd1, 32'h4);

    wr(2'd0, 32'h3f);
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h2);
    set_in(3'b001); ticks(4);
    set_in(3'b000); ticks(5);
`ifdef COUNTER_IRQ_EDGESEL_EN
    expect_reg("edgesel_cnt", 2'd2, 32'h2);
    expect_reg("edgecfg_rd", 2'd3, 32'h2);
`else
    expect_reg("edgesel_cnt", 2'd2, 32'h1);
    expect_reg("edgecfg_rd", 2'd3, 32'h0);
`endif
    wr(2'd3, 32'h0);

    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) set_in(3'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        a = 2'($urandom_range(0, 3));
        wr(a, $urandom);
      end else begin
        tick();
      end
    end

    set_in(3'b000);
    ticks(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) expect_reg($sformatf("mid_rst_reg%0d", i), 2'(i), 32'd0);

    ticks(2);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_irq_ctrl.md
Name: counter_irq_ctrl

Overview:
Downstream event/interrupt stage for the 3-channel counter. Samples the three counter terminal-count outputs (counter0_OUT..counter2_OUT), which are generated in the clk0/clk1/clk2 domains. Synchronises them into the CPU clock domain, detects edges, latches per-channel pending flags and keeps saturating event counts. Drives one maskable interrupt line, with a small 4-word register window on the CPU peripheral bus.

Parameters:
N_CH, 3, number of counter channels (fixed at 3; bit layouts below assume 3)
SYNC_STAGES, 2, synchroniser flops per channel (≥2)
EVCNT_W, 8, width of each per-channel saturating event counter

Ports:
clk  in  1  CPU/bus clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
counter_out_in  in  3  {counter2_OUT, counter1_OUT, counter0_OUT}, asynchronous to clk
bus_we  in  1  register write strobe, one clk cycle per write
bus_addr  in  2  register select
bus_wdata  in  32  write data
bus_rdata  out  32  read data, combinational from bus_addr
irq  out  1  registered interrupt request, active high

Behaviour:
- Clocking/reset: one clock (clk); reset synchronous, active-high (rst). On rst: all sync flops, prev flops, pending, overflow, mask, event counts and irq are 0; edgecfg is 0 (rising). bus_rdata reflects the reset register contents.
- Per channel: SYNC_STAGES-flop synchroniser → sync, plus prev flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - event is selected by edgecfg (rising only when the option is absent).
- Latency (SYNC_STAGES=2): input high before edge E0 → pending visible after E2 → irq high after E3.
- A level already high when rst deasserts is detected as a rising edge. Upstream counters reset low, so this is harmless.
- Register map (unused bits read 0, writes ignored):
  - addr 0 STATUS: [2:0] pending, [5:3] overflow. Write-1-to-clear; 0 bits leave state unchanged.
  - addr 1 MASK: [2:0] irq enable per channel, R/W.
  - addr 2 EVCNT: [7:0] ch0, [15:8] ch1, [23:16] ch2. Each count increments per event and saturates at 0xFF. Any write clears all three counts.
  - addr 3 EDGECFG: see Optional Feature.
- Event on channel i:
  - pending[i] ← 1.
  - If pending[i] was already 1 before this cycle, overflow[i] ← 1.
  - evcnt[i] ← min(evcnt[i]+1, 0xFF).
- Simultaneous events:
  - Event and W1C on the same bit in the same cycle: set wins; pending stays 1, and overflow is evaluated against the pre-clear value.
  - Event and EVCNT write in the same cycle: count becomes 1.
- irq ← |(pending & mask), registered. Clearing the mask or pending drops irq on the next edge.
- rst mid-operation: all state is abandoned at the next clk edge. An event in flight in the synchroniser is lost.

Optional Feature:
Macro COUNTER_IRQ_EDGESEL_EN.
- Defined: EDGECFG is R/W, 2 bits per channel ([1:0] ch0, [3:2] ch1, [5:4] ch2).
  - 00 rising, 01 falling, 10 both edges, 11 channel disabled (no events; pending held).
  - A config change takes effect on the next cycle and produces no spurious event.
- Undefined: rising edge only; addr 3 reads 0 and writes are ignored; no EDGECFG storage.

Decomposition:
- Package counter_irq_pkg holds:
  - register address constants (ADDR_STATUS=0, ADDR_MASK=1, ADDR_EVCNT=2, ADDR_EDGECFG=3);
  - edge-mode encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF);
  - the STATUS bit-field offsets.
- Sub-module counter_irq_sync_edge: one channel's synchroniser, prev flop and rise/fall outputs. It is instantiated N_CH times; top level holds the registers and the irq flop.

Test Plan:
- Reset: assert rst 2 cycles with inputs 0 → bus_rdata=0 at every address; irq=0.
- Rising-edge latency: MASK=0x1, raise input bit0 → STATUS reads 0x001 after 3rd clk edge; irq=1 after 4th; W1C 0x1 → irq=0 two edges later.
- Overflow/saturation: 300 pulses on ch1 (each ≥4 clk wide, gap ≥4), no clears → EVCNT[15:8]=0xFF, STATUS=0x012; write 0x012 to STATUS → 0.
- Set-vs-clear race: W1C bit2 issued in the exact cycle ch2's edge is detected → pending[2] remains 1, overflow[2]=1 only if pending was already set.
- Mask: pending=0x7, MASK=0 → irq=0; MASK=0x4 → irq=1 next edge.
- With COUNTER_IRQ_EDGESEL_EN: EDGECFG=0x02 (ch0 both), pulse ch0 once → EVCNT[7:0]=2. Without the macro, the same stimulus gives 1, and addr 3 reads 0.
